// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC scheduler: widths, default core latency
// and the in-flight tag record carried alongside each operation.
package cordic_pkg;

  localparam int ANGLE_W         = 32;
  localparam int DEFAULT_LATENCY = 2;
  localparam int MAX_ID_W        = 3;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants at most one requester per cycle, searching
// upward from the pointer, and moves the pointer past each winner.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] r_rrPtr;
  logic          w_found;
  int            w_j;

  // Grant is a pure function of req and the pointer; reset blocks every grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_j       = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(r_rrPtr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!w_found && !reset && req[w_j]) begin
        w_found    = 1'b1;
        grant[w_j] = 1'b1;
        grant_idx  = IW'(w_j);
      end
    end
  end

  assign grant_any = w_found;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rrPtr <= '0;
    end else if (advance && grant_any) begin
      r_rrPtr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one pipelined cosine core among N_REQ requesters; a tag pipe matched
// to the core latency routes each result back to the requester that issued it.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int LATENCY = DEFAULT_LATENCY,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [ANGLE_W*N_REQ-1:0] req_angle,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [ANGLE_W-1:0]       rsp_data,
  output logic [ANGLE_W-1:0]       core_angle,
  output logic                     core_clk_en,
  input  logic [ANGLE_W-1:0]       core_result,
  output logic                     busy
);

  logic [N_REQ-1:0]   w_grant;
  logic [ID_W-1:0]    w_grantIdx;
  logic               w_grantAny;
  logic               w_tagAny;
  logic [ANGLE_W-1:0] w_coreAngle;
  tag_t               w_lastTag;
  tag_t               r_tag [LATENCY];
  logic [N_REQ-1:0]   r_rspValid;
  logic [ANGLE_W-1:0] r_rspData;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (w_grantAny),
    .grant     (w_grant),
    .grant_idx (w_grantIdx),
    .grant_any (w_grantAny)
  );

  always_comb begin
    w_coreAngle = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_coreAngle = req_angle[ANGLE_W*i +: ANGLE_W];
    end
  end

  // Each stage mirrors one core register, so the last stage lines up with core_result.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_grantAny, id: MAX_ID_W'(w_grantIdx)};
      for (int k = 1; k < LATENCY; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  always_comb begin
    w_tagAny = 1'b0;
    for (int k = 0; k < LATENCY; k++) w_tagAny = w_tagAny | r_tag[k].valid;
  end

  assign w_lastTag = r_tag[LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rspValid <= '0;
      r_rspData  <= '0;
    end else begin
      r_rspValid <= '0;
      if (w_lastTag.valid) begin
        r_rspValid[w_lastTag.id[ID_W-1:0]] <= 1'b1;
        r_rspData                          <= core_result;
      end
    end
  end

  // The core clears itself whenever the enable drops, so keep it up while anything is in flight.
  assign core_clk_en = (w_grantAny | w_tagAny) & ~reset;
  assign req_ready   = w_grant;
  assign core_angle  = w_coreAngle;
  assign rsp_valid   = r_rspValid;
  assign rsp_data    = r_rspData;
  assign busy        = w_grantAny | w_tagAny | (|r_rspValid);

endmodule
